dmem_responder: RTL and testbench

//   Data-memory responder: the RAM side of the MEM-stage load/store interface.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 56 +++++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master) and the RAM (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 7
);
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_perr;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_perr
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_perr
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage with synchronous write and a registered read port that reads as zero when idle.
// Optional parity column enabled by the DMEM_PARITY_EN macro.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              perr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              perr_q, perr_d;

  always_ff @(posedge clock) begin
    if (wr_en) mem[addr] <= wdata;
  end

`ifdef DMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) par_mem[addr] <= ^wdata;
  end

  always_comb perr_d = rd_en & ((^mem[addr]) != par_mem[addr]);
`else
  always_comb perr_d = 1'b0;
`endif

  // Read register holds zero unless a load is being serviced this edge.
  always_comb rdata_d = rd_en ? mem[addr] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  assign rdata = rdata_q;
  assign perr  = perr_q;

endmodule

// File: rtl/dmem_responder.sv
// RAM side of the MEM-stage load/store port: one request at a time, WAIT_STATES idle cycles, one-cycle response.
// Parity checking is enabled by defining DMEM_PARITY_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int WAIT_STATES = 1
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              acc_en;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic              arr_perr;

  // With zero wait states the array is accessed straight from the bus on the accept edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            acc_en    = 1'b1;
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            state_d   = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .wr_en(acc_en & acc_write),
    .rd_en(acc_en & ~acc_write),
    .addr (acc_addr),
    .wdata(acc_wdata),
    .rdata(arr_rdata),
    .perr (arr_perr)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = arr_rdata;
  assign bus.rsp_perr  = arr_perr;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 2 wait states share clock and reset.
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_PARITY_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid_s [3];
  logic        req_write_s [3];
  logic [6:0]  req_addr_s  [3];
  logic [31:0] req_wdata_s [3];
  logic        req_ready_s [3];
  logic        rsp_valid_s [3];
  logic [31:0] rsp_rdata_s [3];
  logic        rsp_perr_s  [3];

  int checks   = 0;
  int failures = 0;

  dmem_responder_if #(.ADDR_W(7)) bus0 ();
  dmem_responder_if #(.ADDR_W(7)) bus1 ();
  dmem_responder_if #(.ADDR_W(7)) bus2 ();

  dmem_responder #(.ADDR_W(7), .WAIT_STATES(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
  dmem_responder #(.ADDR_W(7), .WAIT_STATES(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  dmem_responder #(.ADDR_W(7), .WAIT_STATES(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));

  assign bus0.req_valid = req_valid_s[0];
  assign bus0.req_write = req_write_s[0];
  assign bus0.req_addr  = req_addr_s[0];
  assign bus0.req_wdata = req_wdata_s[0];
  assign req_ready_s[0] = bus0.req_ready;
  assign rsp_valid_s[0] = bus0.rsp_valid;
  assign rsp_rdata_s[0] = bus0.rsp_rdata;
  assign rsp_perr_s[0]  = bus0.rsp_perr;

  assign bus1.req_valid = req_valid_s[1];
  assign bus1.req_write = req_write_s[1];
  assign bus1.req_addr  = req_addr_s[1];
  assign bus1.req_wdata = req_wdata_s[1];
  assign req_ready_s[1] = bus1.req_ready;
  assign rsp_valid_s[1] = bus1.rsp_valid;
  assign rsp_rdata_s[1] = bus1.rsp_rdata;
  assign rsp_perr_s[1]  = bus1.rsp_perr;

  assign bus2.req_valid = req_valid_s[2];
  assign bus2.req_write = req_write_s[2];
  assign bus2.req_addr  = req_addr_s[2];
  assign bus2.req_wdata = req_wdata_s[2];
  assign req_ready_s[2] = bus2.req_ready;
  assign rsp_valid_s[2] = bus2.rsp_valid;
  assign rsp_rdata_s[2] = bus2.rsp_rdata;
  assign rsp_perr_s[2]  = bus2.rsp_perr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called one time unit after a rising edge; returns at the same phase once the responder is idle again.
  task automatic applyStimulus(input int d, input logic wr, input logic [6:0] addr, input logic [31:0] wdata,
                               output int lat, output int busy, output int pulses,
                               output logic [31:0] rdata, output logic perr);
    int k;
    lat = -1; busy = 0; pulses = 0; rdata = '0; perr = 1'b0;
    req_valid_s[d] = 1'b1;
    req_write_s[d] = wr;
    req_addr_s[d]  = addr;
    req_wdata_s[d] = wdata;
    k = 0;
    while (!req_ready_s[d] && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    if (!req_ready_s[d]) begin
      req_valid_s[d] = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_valid_s[d] = 1'b0;
    req_write_s[d] = ~wr;
    req_addr_s[d]  = ~addr;
    req_wdata_s[d] = ~wdata;
    for (int i = 1; i <= 20; i++) begin
      if (!req_ready_s[d]) busy++;
      if (rsp_valid_s[d]) begin
        pulses++;
        if (lat < 0) begin
          lat   = i;
          rdata = rsp_rdata_s[d];
          perr  = rsp_perr_s[d];
        end
      end
      if (req_ready_s[d] && lat >= 0) break;
      @(posedge clock); #1;
    end
  endtask

  task automatic checkTransaction(input string tag, input int d, input logic wr, input logic [6:0] addr,
                                  input logic [31:0] wdata, input int exp_lat,
                                  input logic [31:0] exp_rdata, input logic exp_perr);
    int lat, busy, pulses;
    logic [31:0] rdata;
    logic perr;
    applyStimulus(d, wr, addr, wdata, lat, busy, pulses, rdata, perr);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(exp_lat));
    checkOutput({tag, "_pulses"}, 32'(pulses), 32'd1);
    checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_perr"}, {31'd0, perr}, {31'd0, exp_perr});
  endtask

  initial begin
    int first_rsp, second_rsp, ready_hi, stray;
    logic [31:0] rd1, rd2;

    for (int d = 0; d < 3; d++) begin
      req_valid_s[d] = 1'b0;
      req_write_s[d] = 1'b0;
      req_addr_s[d]  = '0;
      req_wdata_s[d] = '0;
    end
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("rst_ready%0d", d), {31'd0, req_ready_s[d]}, 32'd1);
      checkOutput($sformatf("rst_rsp_valid%0d", d), {31'd0, rsp_valid_s[d]}, 32'd0);
      checkOutput($sformatf("rst_rdata%0d", d), rsp_rdata_s[d], 32'd0);
      checkOutput($sformatf("rst_perr%0d", d), {31'd0, rsp_perr_s[d]}, 32'd0);
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    checkTransaction("ws1_store5", 1, 1'b1, 7'd5, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    checkTransaction("ws1_load5", 1, 1'b0, 7'd5, 32'h0, 2, 32'hDEADBEEF, 1'b0);

    checkTransaction("ws0_load3", 0, 1'b0, 7'd3, 32'h0, 1, 32'h0, 1'b0);

    checkTransaction("ws0_store127", 0, 1'b1, 7'd127, 32'h1, 1, 32'h0, 1'b0);
    checkTransaction("ws0_store0", 0, 1'b1, 7'd0, 32'h2, 1, 32'h0, 1'b0);
    checkTransaction("ws0_load127", 0, 1'b0, 7'd127, 32'h0, 1, 32'h1, 1'b0);
    checkTransaction("ws0_load0", 0, 1'b0, 7'd0, 32'h0, 1, 32'h2, 1'b0);

    checkTransaction("ws2_store20", 2, 1'b1, 7'd20, 32'h11111111, 3, 32'h0, 1'b0);
    checkTransaction("ws2_store21", 2, 1'b1, 7'd21, 32'h22222222, 3, 32'h0, 1'b0);

    // Second load is held on the bus from the cycle after the first accept.
    req_valid_s[2] = 1'b1;
    req_write_s[2] = 1'b0;
    req_addr_s[2]  = 7'd20;
    @(posedge clock); #1;
    req_addr_s[2] = 7'd21;
    first_rsp = -1; second_rsp = -1; ready_hi = -1; rd1 = '0; rd2 = '0;
    for (int i = 1; i <= 9; i++) begin
      if (rsp_valid_s[2]) begin
        if (first_rsp < 0) begin
          first_rsp = i;
          rd1 = rsp_rdata_s[2];
        end else if (second_rsp < 0) begin
          second_rsp = i;
          rd2 = rsp_rdata_s[2];
        end
      end
      if (req_ready_s[2] && ready_hi < 0) ready_hi = i;
      if (!req_ready_s[2] && ready_hi >= 0 && i > ready_hi) req_valid_s[2] = 1'b0;
      @(posedge clock); #1;
    end
    req_valid_s[2] = 1'b0;
    checkOutput("b2b_first_rsp", 32'(first_rsp), 32'd3);
    checkOutput("b2b_ready_high", 32'(ready_hi), 32'd4);
    checkOutput("b2b_second_rsp", 32'(second_rsp), 32'd7);
    checkOutput("b2b_rdata1", rd1, 32'h11111111);
    checkOutput("b2b_rdata2", rd2, 32'h22222222);

    // Reset lands while the store is still waiting, so it must never reach the array.
    req_valid_s[2] = 1'b1;
    req_write_s[2] = 1'b1;
    req_addr_s[2]  = 7'd9;
    req_wdata_s[2] = 32'hCAFE0000;
    @(posedge clock); #1;
    req_valid_s[2] = 1'b0;
    checkOutput("mid_wait_ready", {31'd0, req_ready_s[2]}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'd0, req_ready_s[2]}, 32'd1);
    checkOutput("mid_rst_rsp_valid", {31'd0, rsp_valid_s[2]}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (rsp_valid_s[2]) stray++;
    end
    checkOutput("post_rst_stray", 32'(stray), 32'd0);
    checkTransaction("ws2_load9", 2, 1'b0, 7'd9, 32'h0, 3, 32'h0, 1'b0);

    checkTransaction("ws1_store7", 1, 1'b1, 7'd7, 32'h000000FF, 2, 32'h0, 1'b0);
    u_dut1.u_array.mem[7] = u_dut1.u_array.mem[7] ^ 32'h1;
    checkTransaction("ws1_load7_flip", 1, 1'b0, 7'd7, 32'h0, 2, 32'h000000FE, EXP_PERR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
